cenc_ctrl: RTL and testbench
============================

# cenc_ctrl

Frame sequencer for the channel encoder. Per frame it:
- builds the 24-bit SIGNAL field from a rate/length request and shifts it serially into the signal encoder input;
- meters exactly `length*8` payload bits from an upstream bit source into the payload encoder input;
- waits for the puncturer's done flag, then issues the one-cycle done-reset pulse that re-arms the encoder chain.

It sits between the MAC-side frame source and the encoder top; all its outputs drive encoder inputs directly.

## Interface
Parameters:
- `LEN_W`, 12, width of the byte-length field.
- `TMO_CYC`, 4096, done-wait watchdog limit in cycles (used only with `CENC_CTRL_TIMEOUT_EN`).

Ports:
- `clk` in 1: single clock. All logic runs on it.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: frame request, sampled only in IDLE.
- `rate` in 4: RATE code, latched on accepted `start`.
- `length` in `LEN_W`: payload byte count, latched on accepted `start`.
- `busy` out 1: frame in progress.
- `err_len` out 1: one-cycle pulse when `start` arrives with `length`==0.
- `err_tmo` out 1: one-cycle pulse on watchdog expiry. Tied 0 without the macro.
- `sig_do` out 1: SIGNAL bit to the signal encoder.
- `sig_do_vld` out 1: SIGNAL bit valid.
- `sig_init` out 6: encoder LSR init. Constant 6'b000000.
- `src_di` in 1: payload bit from upstream.
- `src_vld` in 1: upstream bit valid.
- `src_rdy` out 1: controller ready for a payload bit.
- `pld_do` out 1: payload bit to the payload encoder.
- `pld_do_vld` out 1: payload bit valid.
- `ppu_done_flag` in 1: puncturer frame-complete flag.
- `done_rst` out 1: one-cycle re-arm pulse to the encoder chain.
- `frame_done` out 1: one-cycle completion pulse, coincident with `done_rst`.

## Operation
States: IDLE, SIG, PLD, WAIT, FIN.

- **IDLE**
  - `start`=1 with `length`!=0: latch `rate`/`length`, go to SIG.
  - `start`=1 with `length`==0: pulse `err_len`, stay in IDLE.
- **SIG**
  - Shift 24 bits, LSB first, one per cycle, `sig_do_vld`=1 throughout:
    - bits 0–3 = `rate[0..3]`;
    - bit 4 = 0;
    - bits 5–16 = `length[0..11]`;
    - bit 17 = even parity over bits 0–16;
    - bits 18–23 = 0.
  - A 5-bit counter reaching 23 moves the FSM to PLD.
- **PLD**
  - `src_rdy`=1. A bit transfers when `src_rdy && src_vld`.
  - The transferred bit appears on `pld_do` with `pld_do_vld`=1 on the next cycle.
  - A (`LEN_W`+3)-bit counter counts transfers. On the transfer that reaches `length*8`, drop `src_rdy` on the next cycle and go to WAIT.
  - `src_vld` low stalls the counter; there is no limit on gaps.
- **WAIT**
  - `src_rdy`=0. Go to FIN when `ppu_done_flag`=1.
  - With the macro enabled, the watchdog also exits to FIN (see Configuration).
- **FIN**
  - One cycle: `done_rst`=1, `frame_done`=1. Next state is IDLE.

General rules:
- `start` outside IDLE is ignored, with no error.
- `ppu_done_flag` outside WAIT is ignored.
- Reset mid-frame: FSM to IDLE and all counters cleared at the next edge. No `done_rst` is generated.

## Timing
- All outputs are registered.
- Reset values: every output is 0, including `sig_init`.
- Accepted `start` at cycle T:
  - SIGNAL bit k is on `sig_do` at T+1+k, k=0..23;
  - `busy` is 1 from T+1;
  - `src_rdy` is 1 from T+25.
- Last payload transfer at cycle P:
  - final `pld_do_vld` at P+1;
  - `src_rdy`=0 at P+1;
  - WAIT from P+1.
- `ppu_done_flag` sampled high at cycle D (in WAIT):
  - `done_rst`, `frame_done` at D+1;
  - `busy`=0 at D+2;
  - a new `start` is accepted at D+2.
- Minimum frame length is 24 + 8 + 2 cycles, plus the done latency.
- `err_len` is asserted the cycle after the offending `start`.

## Configuration
`CENC_CTRL_TIMEOUT_EN`:
- **Defined:** a 16-bit counter runs in WAIT. If it reaches `TMO_CYC` without `ppu_done_flag`:
  - pulse `err_tmo`;
  - go to FIN, which still issues `done_rst`/`frame_done`.
  - The counter clears on leaving WAIT.
- **Undefined:** WAIT holds indefinitely, and `err_tmo` is constant 0.

## Test plan
- Nominal SIGNAL: `rate`=4'b1101, `length`=100, `start` → `sig_do` sequence 1,0,1,1,0, 0,0,1,0,0,1,1,0,0,0,0,0, parity 0, then six 0s, at T+1..T+24.
- Payload metering: `length`=3 with `src_vld` always high → exactly 24 `pld_do_vld` beats, bits matching `src_di` with 1-cycle delay. `src_rdy` falls one cycle after the 24th transfer.
- Stall and edge cases: `src_vld` toggling 1,0 during PLD → counter advances only on valid beats. `start` with `length`=0 → `err_len` pulse, `busy` stays 0. `start` during PLD → ignored.
- Done handshake: `ppu_done_flag` high 5 cycles into WAIT → `done_rst`/`frame_done` one cycle wide, and a back-to-back `start` accepted 2 cycles after the flag.
- Reset mid-SIG at bit 10 → all outputs 0 next cycle, no `done_rst`. A following `start` restarts from bit 0.
- With `CENC_CTRL_TIMEOUT_EN` and `TMO_CYC`=16, no `ppu_done_flag` → `err_tmo` pulse after 16 WAIT cycles, followed by `done_rst`. Without the macro, `busy` stays 1.

Source files
------------

// File: rtl/cenc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cenc_ctrl_if
// Description : Frame request, SIGNAL, payload and done-handshake bundle
//               between the channel-encoder frame sequencer and its
//               environment. The slave modport is the sequencer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface cenc_ctrl_if #(
  parameter int LEN_W = 12
);
  // Frame request
  logic             start;
  logic [3:0]       rate;
  logic [LEN_W-1:0] length;
  logic             busy;
  logic             err_len;
  logic             err_tmo;
  // SIGNAL field to the signal encoder
  logic             sig_do;
  logic             sig_do_vld;
  logic [5:0]       sig_init;
  // Payload path
  logic             src_di;
  logic             src_vld;
  logic             src_rdy;
  logic             pld_do;
  logic             pld_do_vld;
  // Done handshake with the encoder chain
  logic             ppu_done_flag;
  logic             done_rst;
  logic             frame_done;

  modport master (
    output start, rate, length, src_di, src_vld, ppu_done_flag,
    input  busy, err_len, err_tmo, sig_do, sig_do_vld, sig_init,
           src_rdy, pld_do, pld_do_vld, done_rst, frame_done
  );

  modport slave (
    input  start, rate, length, src_di, src_vld, ppu_done_flag,
    output busy, err_len, err_tmo, sig_do, sig_do_vld, sig_init,
           src_rdy, pld_do, pld_do_vld, done_rst, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/cenc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cenc_ctrl
// Description : Channel-encoder frame sequencer. Shifts the 24-bit SIGNAL
//               field out LSB first, meters length*8 payload bits from the
//               upstream source, then waits for the puncturer done flag and
//               issues the one-cycle done_rst / frame_done pulse.
//               Optional feature macro: CENC_CTRL_TIMEOUT_EN (done-wait
//               watchdog of TMO_CYC cycles, reported on err_tmo).
// Revision    : 1.0 - initial release
// ============================================================================
module cenc_ctrl #(
  parameter int LEN_W   = 12,
  parameter int TMO_CYC = 4096
) (
  input  wire logic  clk,
  input  wire logic  rst,
  cenc_ctrl_if.slave bus
);

  localparam int CNT_W = LEN_W + 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SIG  = 3'd1,
    ST_PLD  = 3'd2,
    ST_WAIT = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  state_t           state_q,      state_d;
  logic [4:0]       bit_cnt_q,    bit_cnt_d;
  logic [22:0]      sig_sr_q,     sig_sr_d;
  logic [LEN_W-1:0] len_q,        len_d;
  logic [CNT_W-1:0] pld_cnt_q,    pld_cnt_d;
  logic             busy_q,       busy_d;
  logic             err_len_q,    err_len_d;
  logic             err_tmo_q,    err_tmo_d;
  logic             sig_do_q,     sig_do_d;
  logic             sig_vld_q,    sig_vld_d;
  logic             src_rdy_q,    src_rdy_d;
  logic             pld_do_q,     pld_do_d;
  logic             pld_vld_q,    pld_vld_d;
  logic             done_rst_q,   done_rst_d;
  logic             frame_done_q, frame_done_d;

  logic [23:0]      w_sig_word;
  logic             w_xfer;
  logic [CNT_W-1:0] w_pld_tgt;
  logic             w_pld_last;
  logic             w_tmo_hit;

  // SIGNAL layout: rate[3:0], reserved 0, length[11:0], even parity over
  // the 17 preceding bits, six zero tail bits. Lengths narrower than 12
  // bits are zero-extended; wider ones keep their low 12 bits.
  function automatic logic [23:0] sig_word(input logic [3:0] r,
                                           input logic [LEN_W-1:0] l);
    logic [11:0] l12;
    logic [16:0] lo;
    l12 = 12'(l);
    lo  = {l12, 1'b0, r};
    return {6'b000000, ^lo, lo};
  endfunction

  // The word is built straight from the request so bit 0 can be driven
  // on the cycle right after an accepted start.
  assign w_sig_word = sig_word(bus.rate, bus.length);
  assign w_xfer     = src_rdy_q & bus.src_vld;
  assign w_pld_tgt  = {len_q, 3'b000};
  assign w_pld_last = ((pld_cnt_q + CNT_W'(1)) == w_pld_tgt);

`ifdef CENC_CTRL_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;

  assign w_tmo_hit = (state_q == ST_WAIT) && !bus.ppu_done_flag &&
                     (tmo_q == 16'(TMO_CYC - 1));

  // Watchdog counts WAIT cycles without the done flag; cleared elsewhere.
  always_comb begin
    tmo_d = '0;
    if (state_q == ST_WAIT && !bus.ppu_done_flag) tmo_d = tmo_q + 16'd1;
  end

  // Watchdog register.
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  logic tmo_unused;
  assign w_tmo_hit  = 1'b0;
  assign tmo_unused = (TMO_CYC == 0);
`endif

  // Next-state and registered-output decode for the frame FSM.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    sig_sr_d     = sig_sr_q;
    len_d        = len_q;
    pld_cnt_d    = pld_cnt_q;
    busy_d       = busy_q;
    err_len_d    = 1'b0;
    err_tmo_d    = 1'b0;
    sig_do_d     = 1'b0;
    sig_vld_d    = 1'b0;
    src_rdy_d    = 1'b0;
    pld_do_d     = pld_do_q;
    pld_vld_d    = 1'b0;
    done_rst_d   = 1'b0;
    frame_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          if (bus.length == '0) begin
            err_len_d = 1'b1;
          end else begin
            state_d   = ST_SIG;
            len_d     = bus.length;
            bit_cnt_d = 5'd0;
            sig_do_d  = w_sig_word[0];
            sig_sr_d  = w_sig_word[23:1];
            sig_vld_d = 1'b1;
            busy_d    = 1'b1;
          end
        end
      end

      // bit_cnt_q is the index of the SIGNAL bit currently on sig_do.
      ST_SIG: begin
        if (bit_cnt_q == 5'd23) begin
          state_d   = ST_PLD;
          src_rdy_d = 1'b1;
          pld_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          sig_do_d  = sig_sr_q[0];
          sig_sr_d  = {1'b0, sig_sr_q[22:1]};
          sig_vld_d = 1'b1;
        end
      end

      ST_PLD: begin
        src_rdy_d = 1'b1;
        if (w_xfer) begin
          pld_do_d  = bus.src_di;
          pld_vld_d = 1'b1;
          pld_cnt_d = pld_cnt_q + CNT_W'(1);
          if (w_pld_last) begin
            src_rdy_d = 1'b0;
            state_d   = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (bus.ppu_done_flag) begin
          state_d      = ST_FIN;
          done_rst_d   = 1'b1;
          frame_done_d = 1'b1;
        end else if (w_tmo_hit) begin
          state_d      = ST_FIN;
          done_rst_d   = 1'b1;
          frame_done_d = 1'b1;
          err_tmo_d    = 1'b1;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      sig_sr_q     <= '0;
      len_q        <= '0;
      pld_cnt_q    <= '0;
      busy_q       <= 1'b0;
      err_len_q    <= 1'b0;
      err_tmo_q    <= 1'b0;
      sig_do_q     <= 1'b0;
      sig_vld_q    <= 1'b0;
      src_rdy_q    <= 1'b0;
      pld_do_q     <= 1'b0;
      pld_vld_q    <= 1'b0;
      done_rst_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      sig_sr_q     <= sig_sr_d;
      len_q        <= len_d;
      pld_cnt_q    <= pld_cnt_d;
      busy_q       <= busy_d;
      err_len_q    <= err_len_d;
      err_tmo_q    <= err_tmo_d;
      sig_do_q     <= sig_do_d;
      sig_vld_q    <= sig_vld_d;
      src_rdy_q    <= src_rdy_d;
      pld_do_q     <= pld_do_d;
      pld_vld_q    <= pld_vld_d;
      done_rst_q   <= done_rst_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.err_len    = err_len_q;
  assign bus.err_tmo    = err_tmo_q;
  assign bus.sig_do     = sig_do_q;
  assign bus.sig_do_vld = sig_vld_q;
  assign bus.sig_init   = 6'b000000;
  assign bus.src_rdy    = src_rdy_q;
  assign bus.pld_do     = pld_do_q;
  assign bus.pld_do_vld = pld_vld_q;
  assign bus.done_rst   = done_rst_q;
  assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_cenc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cenc_ctrl
// Description : Directed bench for cenc_ctrl: SIGNAL serialisation, payload
//               metering with and without stalls, done handshake, length
//               error, mid-frame reset and the done-wait behaviour with or
//               without CENC_CTRL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cenc_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [23:0] sig_exp;
  logic [23:0] pat;
  logic [30:0] pat2;
  logic [15:0] outs;

  cenc_ctrl_if #(.LEN_W(12)) bus ();

  cenc_ctrl #(
    .LEN_W  (12),
    .TMO_CYC(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  assign outs = {bus.busy, bus.err_len, bus.err_tmo, bus.sig_do,
                 bus.sig_do_vld, bus.sig_init, bus.src_rdy, bus.pld_do,
                 bus.pld_do_vld, bus.done_rst, bus.frame_done};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst               = 1'b1;
    bus.start         = 1'b0;
    bus.rate          = 4'd0;
    bus.length        = 12'd0;
    bus.src_di        = 1'b0;
    bus.src_vld       = 1'b0;
    bus.ppu_done_flag = 1'b0;
    repeat (3) tick();
    chkv("reset_outs", outs, 16'h0000);
    rst = 1'b0;
    tick();
    chkv("idle_outs", outs, 16'h0000);

    // Nominal SIGNAL: rate 1101, length 100
    sig_exp    = 24'h000C8D;
    bus.start  = 1'b1;
    bus.rate   = 4'b1101;
    bus.length = 12'd100;
    tick();
    bus.start = 1'b0;
    chk1("busy_T1", bus.busy, 1'b1);
    for (int k = 0; k < 24; k++) begin
      chk1($sformatf("sigA_bit%0d", k), bus.sig_do, sig_exp[k]);
      chk1($sformatf("sigA_vld%0d", k), bus.sig_do_vld, 1'b1);
      chk1($sformatf("sigA_rdy%0d", k), bus.src_rdy, 1'b0);
      tick();
    end
    chk1("sigA_rdy_T25", bus.src_rdy, 1'b1);
    chk1("sigA_vld_T25", bus.sig_do_vld, 1'b0);
    // abandon the long frame with a reset while in PLD
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chkv("abortA_outs", outs, 16'h0000);

    // Frame B: rate 0000, length 3, continuous source
    sig_exp    = 24'h000060;
    pat        = 24'hA5C36E;
    bus.start  = 1'b1;
    bus.rate   = 4'b0000;
    bus.length = 12'd3;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 24; k++) begin
      chk1($sformatf("sigB_bit%0d", k), bus.sig_do, sig_exp[k]);
      tick();
    end
    chk1("sigB_rdy_T25", bus.src_rdy, 1'b1);
    for (int i = 0; i < 24; i++) begin
      bus.src_di  = pat[i];
      bus.src_vld = 1'b1;
      bus.start   = (i == 5);
      bus.length  = (i == 5) ? 12'd0 : 12'd3;
      tick();
      chk1($sformatf("pldB_vld%0d", i), bus.pld_do_vld, 1'b1);
      chk1($sformatf("pldB_bit%0d", i), bus.pld_do, pat[i]);
      chk1($sformatf("pldB_rdy%0d", i), bus.src_rdy, (i < 23));
      chk1($sformatf("pldB_errlen%0d", i), bus.err_len, 1'b0);
    end
    bus.src_vld = 1'b0;
    bus.start   = 1'b0;
    for (int w = 0; w < 4; w++) begin
      tick();
      chk1($sformatf("waitB_done%0d", w), bus.done_rst, 1'b0);
      chk1($sformatf("waitB_busy%0d", w), bus.busy, 1'b1);
      chk1($sformatf("waitB_vld%0d", w), bus.pld_do_vld, 1'b0);
      chk1($sformatf("waitB_rdy%0d", w), bus.src_rdy, 1'b0);
    end
    bus.ppu_done_flag = 1'b1;
    tick();
    bus.ppu_done_flag = 1'b0;
    chk1("doneB_rst", bus.done_rst, 1'b1);
    chk1("doneB_frame", bus.frame_done, 1'b1);
    chk1("doneB_busy", bus.busy, 1'b1);
    tick();
    chk1("doneB_rst_off", bus.done_rst, 1'b0);
    chk1("doneB_frame_off", bus.frame_done, 1'b0);
    chk1("doneB_busy_off", bus.busy, 1'b0);

    // Frame C back-to-back: rate 0110, length 2, stalled source
    sig_exp    = 24'h020046;
    pat2       = 31'h2B6E_19D5;
    bus.start  = 1'b1;
    bus.rate   = 4'b0110;
    bus.length = 12'd2;
    tick();
    bus.start = 1'b0;
    chk1("sigC_busy", bus.busy, 1'b1);
    for (int k = 0; k < 24; k++) begin
      chk1($sformatf("sigC_bit%0d", k), bus.sig_do, sig_exp[k]);
      chk1($sformatf("sigC_vld%0d", k), bus.sig_do_vld, 1'b1);
      tick();
    end
    chk1("sigC_rdy_T25", bus.src_rdy, 1'b1);
    for (int j = 0; j < 31; j++) begin
      bus.src_vld = (j % 2 == 0);
      bus.src_di  = pat2[j];
      tick();
      chk1($sformatf("pldC_vld%0d", j), bus.pld_do_vld, (j % 2 == 0));
      if (j % 2 == 0) chk1($sformatf("pldC_bit%0d", j), bus.pld_do, pat2[j]);
      chk1($sformatf("pldC_rdy%0d", j), bus.src_rdy, (j < 30));
    end
    bus.src_vld = 1'b0;
`ifdef CENC_CTRL_TIMEOUT_EN
    for (int w = 0; w < 15; w++) begin
      tick();
      chk1($sformatf("tmoC_err%0d", w), bus.err_tmo, 1'b0);
      chk1($sformatf("tmoC_done%0d", w), bus.done_rst, 1'b0);
    end
    tick();
    chk1("tmoC_err", bus.err_tmo, 1'b1);
    chk1("tmoC_done", bus.done_rst, 1'b1);
    chk1("tmoC_frame", bus.frame_done, 1'b1);
    tick();
    chk1("tmoC_err_off", bus.err_tmo, 1'b0);
    chk1("tmoC_busy_off", bus.busy, 1'b0);
`else
    for (int w = 0; w < 40; w++) begin
      tick();
      chk1($sformatf("holdC_busy%0d", w), bus.busy, 1'b1);
      chk1($sformatf("holdC_done%0d", w), bus.done_rst, 1'b0);
      chk1($sformatf("holdC_tmo%0d", w), bus.err_tmo, 1'b0);
    end
    bus.ppu_done_flag = 1'b1;
    tick();
    bus.ppu_done_flag = 1'b0;
    chk1("doneC_rst", bus.done_rst, 1'b1);
    tick();
    chk1("doneC_busy_off", bus.busy, 1'b0);
`endif

    // Zero-length request
    bus.start  = 1'b1;
    bus.length = 12'd0;
    tick();
    bus.start = 1'b0;
    chk1("errlen_pulse", bus.err_len, 1'b1);
    chk1("errlen_busy", bus.busy, 1'b0);
    chk1("errlen_sigvld", bus.sig_do_vld, 1'b0);
    tick();
    chk1("errlen_off", bus.err_len, 1'b0);
    chk1("errlen_busy2", bus.busy, 1'b0);

    // Reset at SIGNAL bit 10, then restart
    sig_exp    = 24'h000C8D;
    bus.start  = 1'b1;
    bus.rate   = 4'b1101;
    bus.length = 12'd100;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    chk1("rstD_bit10", bus.sig_do, sig_exp[10]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chkv("rstD_outs", outs, 16'h0000);
    tick();
    chkv("rstD_idle", outs, 16'h0000);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk1($sformatf("restart_bit%0d", k), bus.sig_do, sig_exp[k]);
      chk1($sformatf("restart_vld%0d", k), bus.sig_do_vld, 1'b1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
